fft_helpers_sine_stream: RTL and testbench
==========================================

FFT_HELPERS_SINE_STREAM -- requirements
Module: fft_helpers_sine_stream

Interface
REQ-001 SHALL have parameter N, default 8: sine table length; power of two, >= 2.
REQ-002 SHALL have parameter W, default 32: total sample width, two's complement.
REQ-003 SHALL have parameter D, default 16: fractional bits; elaboration error if D >= 32 or D >= W.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port cfg_val, input, 1: burst request valid.
REQ-007 SHALL have port cfg_rdy, output, 1: block can accept a burst request.
REQ-008 SHALL have port cfg_step, input, $clog2(N): phase increment in table entries.
REQ-009 SHALL have port cfg_count, input, 16: number of samples in the burst.
REQ-010 SHALL have port send_val, output, 1: sample valid.
REQ-011 SHALL have port send_rdy, input, 1: consumer ready.
REQ-012 SHALL have port send_msg, output, W: sample value.
REQ-013 SHALL have port send_idx, output, $clog2(N): table index of the current sample.
REQ-014 SHALL have port send_last, output, 1: current sample is the final one of the burst.

Function
REQ-015 Table entry i (0..N-1) SHALL equal sin(2*pi*i/N)*2^D rounded to nearest, ties away from zero, sign-extended to W bits; fixed at elaboration, no runtime writes.
REQ-016 FSM SHALL have exactly two states, IDLE and RUN.
REQ-017 IDLE: cfg_rdy=1, send_val=0, send_last=0.
REQ-018 IDLE, cfg_val=1 and cfg_count>0: latch cfg_step and cfg_count, set phase=0, enter RUN next cycle.
REQ-019 IDLE, cfg_val=1 and cfg_count=0: handshake completes, no samples emitted, remain IDLE.
REQ-020 RUN: cfg_rdy=0 and cfg_val ignored; send_val=1.
REQ-021 RUN: send_msg=table[phase] and send_idx=phase, driven combinationally from the registered phase.
REQ-022 RUN: send_last=1 iff remaining count equals 1.
REQ-023 Transfer occurs on a cycle with send_val=1 and send_rdy=1; on transfer phase <= (phase+step) mod N (natural wrap of $clog2(N) bits) and remaining decrements by 1.
REQ-024 Transfer with send_last=1 SHALL return the FSM to IDLE; cfg_rdy=1 on the following cycle.
REQ-025 With send_rdy=0, send_msg, send_idx and send_last SHALL hold stable; no state change.
REQ-026 Latency: first sample valid exactly one cycle after the cfg handshake cycle; then up to one sample per cycle with send_rdy held high.
REQ-027 Burst length up to 65535 SHALL be supported; step=0 SHALL emit table[0] (zero) repeatedly.
REQ-028 The next burst SHALL restart at phase 0 regardless of where the previous one ended.

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE, phase=0, remaining=0, latched step=0 on that edge, overriding any concurrent handshake.
REQ-030 Outputs after reset: cfg_rdy=1, send_val=0, send_last=0, send_idx=0, send_msg=0.
REQ-031 Reset mid-burst SHALL abandon remaining samples; no sample emitted until a new cfg handshake.

Verification
REQ-032 N=8,W=32,D=16, step=1, count=8, send_rdy=1 -> send_msg 0, 46341, 65536, 46341, 0, -46341, -65536, -46341 on consecutive cycles; send_last only on the 8th; cfg_rdy=1 the cycle after.
REQ-033 Step=3, count=4 -> send_idx 0,3,6,1; send_msg 0, 46341, -65536, 46341.
REQ-034 Step=7, count=3, send_rdy toggled 1,0,0,1,1 -> idx 0,7,6 emitted exactly once each; values stable while send_rdy=0.
REQ-035 cfg_count=0 with cfg_val=1 -> send_val stays 0, cfg_rdy stays 1.
REQ-036 Reset asserted after 2 of 8 samples transferred -> next cycle send_val=0, cfg_rdy=1; new burst step=1 count=1 emits 0 with send_last=1.
REQ-037 cfg_val held high during RUN -> ignored; second burst accepted only after send_last transfer.

Source files
------------

// File: rtl/fft_helpers_sine_stream.sv
// fft_helpers_sine_stream: streams bursts of fixed-point sine samples from an
// elaboration-time table, stepping the phase by a configurable increment.
module fft_helpers_sine_stream #(
    parameter int N = 8,   // table length, power of two, >= 2
    parameter int W = 32,  // sample width, two's complement
    parameter int D = 16   // fractional bits
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_val,
    output logic                 cfg_rdy,
    input  logic [$clog2(N)-1:0] cfg_step,
    input  logic [15:0]          cfg_count,
    output logic                 send_val,
    input  logic                 send_rdy,
    output logic [W-1:0]         send_msg,
    output logic [$clog2(N)-1:0] send_idx,
    output logic                 send_last
);

    localparam int  IW = $clog2(N);
    localparam real PI = 3.14159265358979323846;

    // Parameter sanity checks at elaboration time.
    if ((D >= 32) || (D >= W)) begin : g_bad_d
        $error("fft_helpers_sine_stream: D must be < 32 and < W");
    end
    if ((N < 2) || ((N & (N - 1)) != 0)) begin : g_bad_n
        $error("fft_helpers_sine_stream: N must be a power of two >= 2");
    end

    // Table entry i = round(sin(2*pi*i/N) * 2^D), ties away from zero.
    // The angle is folded into the first quadrant by integer symmetry so the
    // exact zeros and the +/-1.0 peaks come out exact, then a Taylor series
    // evaluates the residual angle (<= pi/2) in double precision.
    function automatic logic [W-1:0] sine_entry(input int idx);
        real                 x;
        real                 term;
        real                 acc;
        real                 scale;
        int                  j;
        logic                neg;
        longint              mag;
        logic signed [W-1:0] res;
        j   = idx;
        neg = 1'b0;
        if ((32'sd2 * j) >= N) begin
            j   = j - (N / 32'sd2);
            neg = 1'b1;
        end
        if ((32'sd4 * j) > N) begin
            j = (N / 32'sd2) - j;
        end
        x    = 2.0 * PI * real'(j) / real'(N);
        acc  = 0.0;
        term = x;
        for (int k = 1; k <= 12; k++) begin
            acc  = acc + term;
            term = -term * x * x / real'((32'sd2 * k) * (32'sd2 * k + 32'sd1));
        end
        scale = 1.0;
        for (int k = 0; k < D; k++) begin
            scale = scale * 2.0;
        end
        // real-to-integer conversion rounds to nearest, ties away from zero
        mag = longint'(acc * scale);
        if (neg) begin
            mag = -mag;
        end
        res = W'(mag);
        return res;
    endfunction

    logic [W-1:0] table_s [N];

    for (genvar g = 0; g < N; g++) begin : g_table
        localparam logic [W-1:0] ENTRY = sine_entry(g);
        assign table_s[g] = ENTRY;
    end

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   phase_q, phase_d;
    logic [IW-1:0]   step_q,  step_d;
    logic [15:0]     remaining_q, remaining_d;

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            step_q      <= '0;
            remaining_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            step_q      <= step_d;
            remaining_q <= remaining_d;
        end
    end

    // Next-state logic and handshake outputs for the IDLE/RUN controller.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        step_d      = step_q;
        remaining_d = remaining_q;
        cfg_rdy     = 1'b0;
        send_val    = 1'b0;
        send_last   = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_rdy = 1'b1;
                if (cfg_val && (cfg_count != 16'd0)) begin
                    step_d      = cfg_step;
                    remaining_d = cfg_count;
                    phase_d     = '0;
                    state_d     = RUN;
                end else begin
                    // zero-length request completes the handshake with no samples
                    state_d = IDLE;
                end
            end
            RUN: begin
                send_val  = 1'b1;
                send_last = (remaining_q == 16'd1);
                if (send_rdy) begin
                    phase_d     = phase_q + step_q;
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sample data path: table lookup on the registered phase, zero while idle.
    always_comb begin
        send_idx = '0;
        send_msg = '0;
        if (state_q == RUN) begin
            send_idx = phase_q;
            send_msg = table_s[phase_q];
        end else begin
            send_idx = '0;
            send_msg = '0;
        end
    end

endmodule

// File: tb/tb_fft_helpers_sine_stream.sv
// Directed self-checking bench for fft_helpers_sine_stream (N=8, W=32, D=16).
module tb_fft_helpers_sine_stream;

    logic        clk;
    logic        reset;
    logic        cfg_val;
    logic        cfg_rdy;
    logic [2:0]  cfg_step;
    logic [15:0] cfg_count;
    logic        send_val;
    logic        send_rdy;
    logic [31:0] send_msg;
    logic [2:0]  send_idx;
    logic        send_last;

    int checks;
    int failures;

    // Hand-computed table: round(sin(2*pi*i/8) * 65536)
    int sine8 [8] = '{0, 46341, 65536, 46341, 0, -46341, -65536, -46341};

    fft_helpers_sine_stream #(.N(8), .W(32), .D(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_val   (cfg_val),
        .cfg_rdy   (cfg_rdy),
        .cfg_step  (cfg_step),
        .cfg_count (cfg_count),
        .send_val  (send_val),
        .send_rdy  (send_rdy),
        .send_msg  (send_msg),
        .send_idx  (send_idx),
        .send_last (send_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_cfg_rdy"}, {31'd0, cfg_rdy}, 32'd1);
        chk({tag, "_send_val"}, {31'd0, send_val}, 32'd0);
        chk({tag, "_send_last"}, {31'd0, send_last}, 32'd0);
    endtask

    task automatic chk_sample(input string tag, input int idx, input logic last);
        chk({tag, "_val"}, {31'd0, send_val}, 32'd1);
        chk({tag, "_cfg_rdy"}, {31'd0, cfg_rdy}, 32'd0);
        chk({tag, "_idx"}, {29'd0, send_idx}, 32'(idx));
        chk({tag, "_msg"}, send_msg, 32'(sine8[idx]));
        chk({tag, "_last"}, {31'd0, send_last}, {31'd0, last});
    endtask

    initial begin
        int idx3 [4] = '{0, 3, 6, 1};
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        cfg_val   = 1'b0;
        cfg_step  = 3'd0;
        cfg_count = 16'd0;
        send_rdy  = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        chk_idle("reset");
        chk("reset_idx", {29'd0, send_idx}, 32'd0);
        chk("reset_msg", send_msg, 32'd0);

        // full-table burst, step 1, count 8
        cfg_val = 1'b1; cfg_step = 3'd1; cfg_count = 16'd8; send_rdy = 1'b1;
        tick();
        cfg_val = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_sample($sformatf("s1_%0d", i), i, (i == 7));
            tick();
        end
        chk_idle("s1_after");

        // step 3, count 4
        cfg_val = 1'b1; cfg_step = 3'd3; cfg_count = 16'd4;
        tick();
        cfg_val = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_sample($sformatf("s3_%0d", i), idx3[i], (i == 3));
            tick();
        end
        chk_idle("s3_after");

        // step 7, count 3, back-pressure 1,0,0,1,1
        cfg_val = 1'b1; cfg_step = 3'd7; cfg_count = 16'd3;
        tick();
        cfg_val = 1'b0;
        send_rdy = 1'b1; chk_sample("s7_c0", 0, 1'b0); tick();
        send_rdy = 1'b0; chk_sample("s7_c1", 7, 1'b0); tick();
        send_rdy = 1'b0; chk_sample("s7_c2", 7, 1'b0); tick();
        send_rdy = 1'b1; chk_sample("s7_c3", 7, 1'b0); tick();
        send_rdy = 1'b1; chk_sample("s7_c4", 6, 1'b1); tick();
        chk_idle("s7_after");

        // zero-length request
        cfg_val = 1'b1; cfg_step = 3'd1; cfg_count = 16'd0;
        tick();
        cfg_val = 1'b0;
        chk_idle("zero_c0");
        tick();
        chk_idle("zero_c1");

        // step 0 repeats table[0]
        cfg_val = 1'b1; cfg_step = 3'd0; cfg_count = 16'd3;
        tick();
        cfg_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_sample($sformatf("st0_%0d", i), 0, (i == 2));
            tick();
        end
        chk_idle("st0_after");

        // reset after two transfers of an 8-sample burst
        cfg_val = 1'b1; cfg_step = 3'd1; cfg_count = 16'd8;
        tick();
        cfg_val = 1'b0;
        chk_sample("rst_s0", 0, 1'b0); tick();
        chk_sample("rst_s1", 1, 1'b0); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("rst_after");
        chk("rst_after_idx", {29'd0, send_idx}, 32'd0);
        tick();
        chk_idle("rst_after2");
        cfg_val = 1'b1; cfg_step = 3'd1; cfg_count = 16'd1;
        tick();
        cfg_val = 1'b0;
        chk_sample("rst_new", 0, 1'b1);
        tick();
        chk_idle("rst_new_after");

        // cfg_val held during RUN is ignored; second burst follows last transfer
        cfg_val = 1'b1; cfg_step = 3'd1; cfg_count = 16'd2;
        tick();
        cfg_step = 3'd2; cfg_count = 16'd2;
        chk_sample("hold_a0", 0, 1'b0); tick();
        chk_sample("hold_a1", 1, 1'b1); tick();
        chk_idle("hold_gap");
        tick();
        cfg_val = 1'b0;
        chk_sample("hold_b0", 0, 1'b0); tick();
        chk_sample("hold_b1", 2, 1'b1); tick();
        chk_idle("hold_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
